pc_stack_unit: RTL and testbench

Saves and restores the 16-bit program counter through the 6502 hardware stack (page 1) for JSR/RTS/RTI/BRK-style sequences. It reads the program counter's PCL/PCH outputs and writes them to memory as two byte pushes. It also reads two bytes back and drives them into the program counter's parallel-load port, optionally incremented. The block owns the 8-bit stack pointer (SP) and sits between the program counter, the memory bus and the control sequencer.

---
 rtl/pc_stack_unit_pkg.sv | 18 +
 rtl/pc_stack_unit_stack_pointer.sv | 40 ++++
 rtl/pc_stack_unit.sv | 181 ++++++++++++++++++
 tb/tb_pc_stack_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the PC save/restore path through the page-1 stack.
package pc_stack_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_H,
        ST_PUSH_L,
        ST_PULL_PRE,
        ST_PULL_L,
        ST_PULL_H,
        ST_PULL_WAIT,
        ST_LOAD
    } stack_state_e;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;
    localparam logic [7:0] SP_RESET_DEFAULT   = 8'hFD;

endpackage

// File: rtl/pc_stack_unit_stack_pointer.sv
// 8-bit stack pointer register with load/decrement/increment (load has priority).
module stack_pointer
    import pc_stack_unit_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] value_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] sp_o
);

    logic [7:0] sp_q;
    logic [7:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (load_i) begin
            sp_d = value_i;
        end else if (dec_i) begin
            sp_d = sp_q - 8'd1;
        end else if (inc_i) begin
            sp_d = sp_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= SP_RESET;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_o = sp_q;

endmodule

// File: rtl/pc_stack_unit.sv
// Pushes/pulls the 16-bit PC through the page-1 stack; every output is a register
// loaded one cycle ahead, so bus signals line up with the state they belong to.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT,
    parameter logic [7:0] SP_RESET   = SP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  PCL_in,
    input  logic [7:0]  PCH_in,
    input  logic        push_req,
    input  logic        pull_req,
    input  logic        pull_inc,
    input  logic        sp_load,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  data_in,
    output logic [15:0] addr_out,
    output logic [7:0]  data_out,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  PCL_out,
    output logic [7:0]  PCH_out,
    output logic        pc_load,
    output logic [7:0]  SP_out,
    output logic        busy,
    output logic        done
);

    stack_state_e state_q, state_d;

    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic [7:0]  pcl_q, pcl_d;
    logic [7:0]  pch_q, pch_d;
    logic        pc_load_q, pc_load_d;
    logic        done_q, done_d;
    logic [7:0]  pcl_latch_q, pcl_latch_d;
    logic        inc_q, inc_d;
    logic [7:0]  lo_q, lo_d;

    logic [7:0]  sp_val;
    logic        sp_ld_en;
    logic        sp_inc_en;
    logic        sp_dec_en;
    logic [15:0] pulled_pc;

    stack_pointer #(
        .SP_RESET(SP_RESET)
    ) u_sp (
        .clk    (clk),
        .reset  (reset),
        .load_i (sp_ld_en),
        .value_i(sp_in),
        .inc_i  (sp_inc_en),
        .dec_i  (sp_dec_en),
        .sp_o   (sp_val)
    );

    // The high byte arrives on data_in in PULL_WAIT; the sum is formed then.
    assign pulled_pc = {data_in, lo_q} + {15'd0, inc_q};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        pcl_d       = pcl_q;
        pch_d       = pch_q;
        pc_load_d   = 1'b0;
        done_d      = 1'b0;
        pcl_latch_d = pcl_latch_q;
        inc_d       = inc_q;
        lo_d        = lo_q;
        sp_ld_en    = 1'b0;
        sp_inc_en   = 1'b0;
        sp_dec_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sp_ld_en = sp_load;
                if (push_req) begin
                    pcl_latch_d = PCL_in;
                    addr_d      = {STACK_PAGE, (sp_load ? sp_in : sp_val)};
                    wdata_d     = PCH_in;
                    we_d        = 1'b1;
                    state_d     = ST_PUSH_H;
                end else if (pull_req) begin
                    inc_d   = pull_inc;
                    state_d = ST_PULL_PRE;
                end
            end
            ST_PUSH_H: begin
                sp_dec_en = 1'b1;
                addr_d    = {STACK_PAGE, sp_val - 8'd1};
                wdata_d   = pcl_latch_q;
                we_d      = 1'b1;
                state_d   = ST_PUSH_L;
            end
            ST_PUSH_L: begin
                sp_dec_en = 1'b1;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_PULL_PRE: begin
                sp_inc_en = 1'b1;
                addr_d    = {STACK_PAGE, sp_val + 8'd1};
                re_d      = 1'b1;
                state_d   = ST_PULL_L;
            end
            ST_PULL_L: begin
                sp_inc_en = 1'b1;
                addr_d    = {STACK_PAGE, sp_val + 8'd1};
                re_d      = 1'b1;
                state_d   = ST_PULL_H;
            end
            ST_PULL_H: begin
                lo_d    = data_in;
                state_d = ST_PULL_WAIT;
            end
            ST_PULL_WAIT: begin
                {pch_d, pcl_d} = pulled_pc;
                pc_load_d      = 1'b1;
                done_d         = 1'b1;
                state_d        = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            pcl_q       <= 8'h00;
            pch_q       <= 8'h00;
            pc_load_q   <= 1'b0;
            done_q      <= 1'b0;
            pcl_latch_q <= 8'h00;
            inc_q       <= 1'b0;
            lo_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            pcl_q       <= pcl_d;
            pch_q       <= pch_d;
            pc_load_q   <= pc_load_d;
            done_q      <= done_d;
            pcl_latch_q <= pcl_latch_d;
            inc_q       <= inc_d;
            lo_q        <= lo_d;
        end
    end

    assign addr_out = addr_q;
    assign data_out = wdata_q;
    assign mem_we   = we_q;
    assign mem_re   = re_q;
    assign PCL_out  = pcl_q;
    assign PCH_out  = pch_q;
    assign pc_load  = pc_load_q;
    assign done     = done_q;
    assign SP_out   = sp_val;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomized bench: stimulus queues expected bus events from a byte-array stack model,
// a negedge monitor pops and compares whenever the DUT strobes anything.
module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  PCL_in = 8'h00;
    logic [7:0]  PCH_in = 8'h00;
    logic        push_req = 1'b0;
    logic        pull_req = 1'b0;
    logic        pull_inc = 1'b0;
    logic        sp_load = 1'b0;
    logic [7:0]  sp_in = 8'h00;
    logic [7:0]  data_in = 8'h00;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  PCL_out;
    logic [7:0]  PCH_out;
    logic        pc_load;
    logic [7:0]  SP_out;
    logic        busy;
    logic        done;

    pc_stack_unit dut (
        .clk     (clk),
        .reset   (reset),
        .PCL_in  (PCL_in),
        .PCH_in  (PCH_in),
        .push_req(push_req),
        .pull_req(pull_req),
        .pull_inc(pull_inc),
        .sp_load (sp_load),
        .sp_in   (sp_in),
        .data_in (data_in),
        .addr_out(addr_out),
        .data_out(data_out),
        .mem_we  (mem_we),
        .mem_re  (mem_re),
        .PCL_out (PCL_out),
        .PCH_out (PCH_out),
        .pc_load (pc_load),
        .SP_out  (SP_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // flags = {mem_we, mem_re, done, pc_load}; addr holds the loaded PC for LOAD events
    typedef struct {
        logic [3:0]  flags;
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    localparam logic [3:0] F_WR   = 4'b1000;
    localparam logic [3:0] F_RD   = 4'b0100;
    localparam logic [3:0] F_DONE = 4'b0010;
    localparam logic [3:0] F_LOAD = 4'b0011;

    ev_t         exp_q[$];
    logic [7:0]  phys_mem [0:255] = '{default: 8'h00};
    logic [7:0]  ref_mem  [0:255] = '{default: 8'h00};
    logic [7:0]  m_sp = 8'hFD;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    bit          mon_en = 1'b0;

    // Page-1 memory seen by the DUT; read data appears one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) phys_mem[addr_out[7:0]] <= data_out;
        data_in <= mem_re ? phys_mem[addr_out[7:0]] : 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (mem_we || mem_re || done || pc_load)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: got flags %b addr %h expected no activity (cycle %0d)",
                         {mem_we, mem_re, done, pc_load}, addr_out, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_flags", 32'({mem_we, mem_re, done, pc_load}), 32'(e.flags));
                chk("event_cycle", cyc, e.cyc);
                if (e.flags == F_WR) begin
                    chk("write_addr", 32'(addr_out), 32'(e.addr));
                    chk("write_data", 32'(data_out), 32'(e.data));
                end else if (e.flags == F_RD) begin
                    chk("read_addr", 32'(addr_out), 32'(e.addr));
                end else if (e.flags == F_LOAD) begin
                    chk("loaded_pc", 32'({PCH_out, PCL_out}), 32'(e.addr));
                end
            end
        end
    end

    task automatic set_noise(input bit noise);
        push_req = noise;
        pull_req = noise;
        sp_load  = noise;
        sp_in    = 8'h40;
    endtask

    task automatic clear_inputs();
        push_req = 1'b0;
        pull_req = 1'b0;
        sp_load  = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] pc, input bit both, input bit ld,
                           input logic [7:0] ldv, input bit noise);
        int n;
        @(negedge clk);
        PCH_in   = pc[15:8];
        PCL_in   = pc[7:0];
        push_req = 1'b1;
        pull_req = both;
        pull_inc = 1'($urandom);
        sp_load  = ld;
        sp_in    = ldv;
        if (ld) m_sp = ldv;
        n = cyc;
        exp_q.push_back('{F_WR, n + 1, {8'h01, m_sp}, pc[15:8]});
        ref_mem[m_sp] = pc[15:8];
        m_sp = m_sp - 8'd1;
        exp_q.push_back('{F_WR, n + 2, {8'h01, m_sp}, pc[7:0]});
        ref_mem[m_sp] = pc[7:0];
        m_sp = m_sp - 8'd1;
        exp_q.push_back('{F_DONE, n + 3, 16'h0000, 8'h00});
        @(negedge clk);
        set_noise(noise);
        PCH_in = 8'($urandom);
        PCL_in = 8'($urandom);
        chk("push_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        clear_inputs();
        chk("push_sp", 32'(SP_out), 32'(m_sp));
        chk("push_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_pull(input bit inc, input bit ld, input logic [7:0] ldv, input bit noise);
        int n;
        logic [7:0]  a_lo, a_hi;
        logic [15:0] pc;
        @(negedge clk);
        pull_req = 1'b1;
        pull_inc = inc;
        sp_load  = ld;
        sp_in    = ldv;
        if (ld) m_sp = ldv;
        n    = cyc;
        a_lo = m_sp + 8'd1;
        a_hi = m_sp + 8'd2;
        pc   = {ref_mem[a_hi], ref_mem[a_lo]} + 16'(inc);
        m_sp = a_hi;
        exp_q.push_back('{F_RD, n + 2, {8'h01, a_lo}, 8'h00});
        exp_q.push_back('{F_RD, n + 3, {8'h01, a_hi}, 8'h00});
        exp_q.push_back('{F_LOAD, n + 5, pc, 8'h00});
        @(negedge clk);
        set_noise(noise);
        pull_inc = ~inc;
        chk("pull_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        chk("pull_busy_load", 32'(busy), 32'd1);
        @(negedge clk);
        clear_inputs();
        chk("pull_sp", 32'(SP_out), 32'(m_sp));
        chk("pull_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        chk("reset_sp", 32'(SP_out), 32'hFD);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", 32'(addr_out), 32'h0000);
        chk("reset_pc_out", 32'({PCH_out, PCL_out, data_out}), 32'h000000);
        chk("reset_strobes", 32'({mem_we, mem_re, pc_load, done}), 32'd0);

        do_push(16'h1234, 1'b0, 1'b0, 8'h00, 1'b0);
        do_pull(1'b1, 1'b0, 8'h00, 1'b0);
        do_pull(1'b0, 1'b1, 8'hFB, 1'b1);
        do_push(16'hABCD, 1'b0, 1'b1, 8'h00, 1'b0);
        do_pull(1'b0, 1'b0, 8'h00, 1'b0);
        do_push(16'hFFFF, 1'b1, 1'b0, 8'h00, 1'b1);
        do_pull(1'b1, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1)
                do_push(16'($urandom), 1'($urandom), ($urandom_range(3, 0) == 0), 8'($urandom), 1'($urandom));
            else
                do_pull(1'($urandom), ($urandom_range(3, 0) == 0), 8'($urandom), 1'($urandom));
        end

        // Reset while the second read is on the bus: the pull must vanish.
        @(negedge clk);
        pull_req = 1'b1;
        pull_inc = 1'b1;
        n = cyc;
        exp_q.push_back('{F_RD, n + 2, {8'h01, m_sp + 8'd1}, 8'h00});
        exp_q.push_back('{F_RD, n + 3, {8'h01, m_sp + 8'd2}, 8'h00});
        @(negedge clk);
        pull_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_sp = 8'hFD;
        chk("midreset_sp", 32'(SP_out), 32'hFD);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_outs", 32'({addr_out, data_out, PCL_out}), 32'd0);
        repeat (6) @(negedge clk);
        chk("midreset_no_load", 32'(pc_load), 32'd0);

        do_push(16'h5A5A, 1'b0, 1'b0, 8'h00, 1'b0);
        do_pull(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
